// File: rtl/hazard_pkg.sv
// Shared encodings, shadow-entry layout and matching helpers for the hazard unit.
package hazard_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {FWD_D_RF = 2'd0, FWD_D_E = 2'd1, FWD_D_M = 2'd2, FWD_D_W = 2'd3} fwd_d_e;
  typedef enum logic [1:0] {FWD_E_PIPE = 2'd0, FWD_E_M = 2'd1, FWD_E_W = 2'd2} fwd_e_e;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md;
    logic       div;
  } shadow_t;

  // A producer can forward only once its result exists (tnew == 0); $0 never matches.
  function automatic logic fwd_hit(shadow_t s, logic [4:0] r);
    return (r != 5'd0) && (s.a3 == r) && (s.tnew == 2'd0);
  endfunction

  function automatic logic hz_hit(shadow_t s, logic [4:0] r, logic [1:0] tuse);
    return (tuse != TUSE_NONE) && (r != 5'd0) && (s.a3 == r) && (tuse < s.tnew);
  endfunction

  function automatic shadow_t age(shadow_t s);
    shadow_t o;
    o = s;
    if (s.tnew != 2'd0) o.tnew = s.tnew - 2'd1;
    return o;
  endfunction

  function automatic fwd_d_e fwd_d_sel(shadow_t e, shadow_t m, shadow_t w, logic [4:0] r);
    if (fwd_hit(e, r)) return FWD_D_E;
    if (fwd_hit(m, r)) return FWD_D_M;
    if (fwd_hit(w, r)) return FWD_D_W;
    return FWD_D_RF;
  endfunction

  function automatic fwd_e_e fwd_e_sel(shadow_t m, shadow_t w, logic [4:0] r);
    if (fwd_hit(m, r)) return FWD_E_M;
    if (fwd_hit(w, r)) return FWD_E_W;
    return FWD_E_PIPE;
  endfunction
endpackage

// File: rtl/hazard_if.sv
// D-stage hazard query and the resulting stall/forward controls.
interface hazard_if;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse1, d_tuse2, d_tnew;
  logic       d_md_start, d_md_is_div, d_hilo_use;
  logic       stall;
  logic [1:0] fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel;

  modport master (
    output d_rs, d_rt, d_a3, d_tuse1, d_tuse2, d_tnew, d_md_start, d_md_is_div, d_hilo_use,
    input  stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel
  );
  modport slave (
    input  d_rs, d_rt, d_a3, d_tuse1, d_tuse2, d_tnew, d_md_start, d_md_is_div, d_hilo_use,
    output stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel
  );
endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Multiply/divide unit occupancy: counter loaded as an md op leaves E.
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_div,
  output logic busy
);
  logic [3:0] cnt;

  // E always drains into M, even when a bubble is injected, so load wins unconditionally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt <= 4'd0;
    else if (load)       cnt <= load_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign busy = load | (cnt != 4'd0);
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward control from E/M/W shadow entries of in-flight writers.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hif
);
  shadow_t e_q, m_q, w_q, d_ent;
  logic    hz, md_busy, stall_int;

  assign d_ent = '{a3:   hif.d_a3,
                   tnew: hif.d_tnew,
                   rs:   hif.d_rs,
                   rt:   hif.d_rt,
                   md:   hif.d_md_start,
                   div:  hif.d_md_start & hif.d_md_is_div};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= stall_int ? '0 : d_ent;
      m_q <= age(e_q);
      w_q <= age(m_q);
    end
  end

  md_busy_cnt #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md_busy (
    .clk      (clk),
    .reset    (reset),
    .load     (e_q.md),
    .load_div (e_q.div),
    .busy     (md_busy)
  );

  // W is never a hazard source: its value reaches D through the forward mux.
  assign hz = hz_hit(e_q, hif.d_rs, hif.d_tuse1) | hz_hit(m_q, hif.d_rs, hif.d_tuse1) |
              hz_hit(e_q, hif.d_rt, hif.d_tuse2) | hz_hit(m_q, hif.d_rt, hif.d_tuse2);
  assign stall_int = hz | (hif.d_hilo_use & md_busy);

  assign hif.stall        = reset & stall_int;
  assign hif.fwd_d_rs_sel = reset ? fwd_d_sel(e_q, m_q, w_q, hif.d_rs) : FWD_D_RF;
  assign hif.fwd_d_rt_sel = reset ? fwd_d_sel(e_q, m_q, w_q, hif.d_rt) : FWD_D_RF;
  assign hif.fwd_e_rs_sel = reset ? fwd_e_sel(m_q, w_q, e_q.rs) : FWD_E_PIPE;
  assign hif.fwd_e_rt_sel = reset ? fwd_e_sel(m_q, w_q, e_q.rt) : FWD_E_PIPE;

  logic unused_fields;
  assign unused_fields = ^{m_q.rs, m_q.rt, m_q.md, m_q.div, w_q.rs, w_q.rt, w_q.md, w_q.div};
endmodule
